// File: rtl/fifo_unpacker.sv
// fifo_unpacker: pops wide words from a val/ack FIFO read port and replays
// each one as IN_WIDTH/OUT_WIDTH narrow slices, least-significant slice first,
// on a val/ack output stream. Also keeps a wrapping count of words popped and
// an idle flag for the surrounding control logic.
module fifo_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IN_WIDTH-1:0]  rdata,
  input  logic                 rval,
  output logic                 rack,
  output logic [OUT_WIDTH-1:0] odata,
  output logic                 oval,
  input  logic                 oack,
  output logic                 olast,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 idle
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // EMPTY: nothing held. SHIFTING: hold_q carries a word being emitted.
  typedef enum logic {
    EMPTY    = 1'b0,
    SHIFTING = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   full_q;
  logic [IN_WIDTH-1:0]    hold_q;
  logic [IN_WIDTH-1:0]    hold_d;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_d;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic                   at_last;
  logic                   pop;

  assign full_q  = (state_q == SHIFTING);
  assign at_last = (idx == LAST_IDX);
  assign pop     = rval && rack;

  // State register: async clear discards any partially emitted word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      hold_q   <= '0;
      idx      <= '0;
      word_cnt <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      idx      <= idx_d;
      word_cnt <= cnt_d;
    end
  end

  // Next-state logic: load on pop, step the slice index on each transfer,
  // and reload straight from the FIFO on the last slice to avoid a bubble.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx;
    cnt_d   = word_cnt;
    case (state_q)
      EMPTY: begin
        if (pop) begin
          state_d = SHIFTING;
          hold_d  = rdata;
          idx_d   = '0;
          cnt_d   = word_cnt + CNT_WIDTH'(1);
        end
      end
      SHIFTING: begin
        if (oack) begin
          if (!at_last) begin
            idx_d = idx + IDX_W'(1);
          end else if (pop) begin
            hold_d = rdata;
            idx_d  = '0;
            cnt_d  = word_cnt + CNT_WIDTH'(1);
          end else begin
            state_d = EMPTY;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    endcase
  end

  // Output logic: slice mux, handshake flags and the combinational pop strobe.
  // rack is gated by reset_n so the FIFO is never popped while in reset.
  always_comb begin
    odata = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx == IDX_W'(i)) begin
        odata = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
    oval  = full_q;
    olast = full_q && at_last;
    rack  = reset_n && rval && (!full_q || (oack && at_last));
    idle  = !full_q && !rval;
  end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: emulates the FIFO with a queue and predicts the
// output stream as a queue of pending slices per popped word.
module tb_fifo_unpacker;

  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int RATIO = IN_W / OUT_W;

  logic             clk;
  logic             reset_n;
  logic [IN_W-1:0]  rdata;
  logic             rval;
  logic             rack;
  logic [OUT_W-1:0] odata;
  logic             oval;
  logic             oack;
  logic             olast;
  logic [15:0]      word_cnt;
  logic             idle;

  logic             rack2;
  logic [OUT_W-1:0] odata2;
  logic             oval2;
  logic             olast2;
  logic [1:0]       word_cnt2;
  logic             idle2;

  fifo_unpacker #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .rdata(rdata), .rval(rval), .rack(rack),
    .odata(odata), .oval(oval), .oack(oack), .olast(olast),
    .word_cnt(word_cnt), .idle(idle)
  );

  // Narrow-counter instance driven in lockstep to observe counter wrap.
  fifo_unpacker #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_WIDTH(2)) dut_w2 (
    .clk(clk), .reset_n(reset_n), .rdata(rdata), .rval(rval), .rack(rack2),
    .odata(odata2), .oval(oval2), .oack(oack), .olast(olast2),
    .word_cnt(word_cnt2), .idle(idle2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned     checks;
  int unsigned     errors;
  logic [IN_W-1:0] fifo_q[$];
  logic [OUT_W-1:0] pend[$];
  int unsigned     cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model
  // to what the next rising edge should do.
  task automatic step(input bit ack, input bit en);
    bit exp_rack;
    logic [IN_W-1:0] w;
    @(negedge clk);
    rval  = en && (fifo_q.size() > 0);
    rdata = rval ? fifo_q[0] : IN_W'($urandom);
    oack  = ack;
    #1;
    exp_rack = rval && ((pend.size() == 0) || (ack && pend.size() == 1));
    chk("oval", 32'(oval), 32'(pend.size() > 0));
    if (pend.size() > 0) chk("odata", 32'(odata), 32'(pend[0]));
    chk("olast", 32'(olast), 32'(pend.size() == 1));
    chk("rack", 32'(rack), 32'(exp_rack));
    chk("idle", 32'(idle), 32'((pend.size() == 0) && !rval));
    chk("word_cnt", 32'(word_cnt), cnt % 65536);
    chk("word_cnt_w2", 32'(word_cnt2), cnt % 4);
    if (ack && pend.size() > 0) void'(pend.pop_front());
    if (exp_rack) begin
      w = fifo_q.pop_front();
      for (int i = 0; i < RATIO; i++) pend.push_back(w[i*OUT_W +: OUT_W]);
      cnt++;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cnt     = 0;
    reset_n = 1'b0;
    rval    = 1'b0;
    oack    = 1'b0;
    rdata   = '0;

    // Reset state, including rack held low with rval raised.
    #1;
    chk("rst_oval", 32'(oval), 32'd0);
    chk("rst_odata", 32'(odata), 32'd0);
    chk("rst_olast", 32'(olast), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rval  = 1'b1;
    rdata = 32'h12345678;
    #1;
    chk("rst_rack", 32'(rack), 32'd0);
    chk("rst_idle_rval", 32'(idle), 32'd0);
    rval = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Single word, then under-run.
    fifo_q.push_back(32'h44332211);
    repeat (7) step(1'b1, 1'b1);

    // Back-to-back words with no gap.
    fifo_q.push_back(32'hDDCCBBAA);
    fifo_q.push_back(32'h04030201);
    repeat (11) step(1'b1, 1'b1);

    // Backpressure while 0x22 is presented.
    fifo_q.push_back(32'h44332211);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("bp_odata", 32'(odata), 32'h22);
    repeat (5) step(1'b1, 1'b1);

    // Five words for counter wrap on the narrow instance.
    for (int i = 0; i < 5; i++) fifo_q.push_back(32'($urandom));
    repeat (24) step(1'b1, 1'b1);

    // Reset mid-word, asserted between edges after slice 0x22 transfers.
    fifo_q.push_back(32'h44332211);
    fifo_q.push_back(32'hA5B6C7D8);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    rval    = 1'b1;
    rdata   = fifo_q[0];
    oack    = 1'b1;
    #1;
    chk("mid_oval", 32'(oval), 32'd0);
    chk("mid_olast", 32'(olast), 32'd0);
    chk("mid_odata", 32'(odata), 32'd0);
    chk("mid_idx", 32'(dut.idx), 32'd0);
    chk("mid_cnt", 32'(word_cnt), 32'd0);
    chk("mid_rack", 32'(rack), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_hold_oval", 32'(oval), 32'd0);
    chk("mid_hold_rack", 32'(rack), 32'd0);
    pend.delete();
    cnt = 0;
    #3;
    reset_n = 1'b1;
    rval    = 1'b0;
    repeat (7) step(1'b1, 1'b1);

    // Randomised traffic: random oack, random FIFO occupancy and rval gaps.
    for (int c = 0; c < 400; c++) begin
      if (fifo_q.size() < 3 && $urandom_range(0, 1) == 1) fifo_q.push_back(32'($urandom));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
    end
    repeat (30) step(1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_unpacker.md
# fifo_unpacker

Read-side consumer for the team's `simple_fifo`-style `val`/`ack` FIFO interface. It pops IN_WIDTH-bit words from a FIFO read port and re-emits each word as IN_WIDTH/OUT_WIDTH narrower slices, least-significant slice first, on a downstream `val`/`ack` stream. It sits between a wide buffering FIFO and a narrow datapath such as a byte-serial transmitter. It also provides a consumed-word counter and an idle flag.

## Interface
- IN_WIDTH, 32, FIFO word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output slice width; RATIO = IN_WIDTH/OUT_WIDTH, RATIO >= 2.
- CNT_WIDTH, 16, width of the consumed-word counter.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rdata  in  IN_WIDTH  FIFO head word; combinationally valid while rval=1.
- rval  in  1  FIFO non-empty.
- rack  out  1  pop strobe; the FIFO head is consumed in any cycle with rval&&rack.
- odata  out  OUT_WIDTH  current output slice.
- oval  out  1  odata valid.
- oack  in  1  downstream accept; a slice transfers in any cycle with oval&&oack.
- olast  out  1  current slice is the last (RATIO-1) slice of its word.
- word_cnt  out  CNT_WIDTH  words popped since reset, modulo 2^CNT_WIDTH.
- idle  out  1  no word held and rval=0.

## Operation
- State:
  - hold_q: IN_WIDTH bits.
  - idx: ceil(log2(RATIO)) bits.
  - full_q: 1 bit. The FSM has two states: EMPTY (full_q=0) and SHIFTING (full_q=1).
- Outputs:
  - odata = hold_q[idx*OUT_WIDTH +: OUT_WIDTH].
  - oval = full_q.
  - olast = full_q && (idx==RATIO-1).
- rack = reset_n && rval && (!full_q || (oack && idx==RATIO-1)). The rack path is combinational from rval and oack.
- EMPTY state:
  - On rval&&rack: hold_q<=rdata, idx<=0, full_q<=1, word_cnt<=word_cnt+1.
  - Otherwise state holds.
- SHIFTING state, slice transfer (oack=1) with idx<RATIO-1: idx<=idx+1.
- SHIFTING state, slice transfer with idx==RATIO-1:
  - If rval=1: reload in the same cycle (hold_q<=rdata, idx<=0, word_cnt increments). full_q stays 1, giving no bubble.
  - If rval=0: full_q<=0, idx<=0, and the FSM returns to EMPTY.
- SHIFTING state, oack=0: all state holds and odata stays stable. Once oval is asserted it is never retracted before its transfer.
- idle = !full_q && !rval.
- word_cnt increments by exactly 1 per pop and wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Reset, asynchronous and usable mid-word:
  - hold_q=0, idx=0, full_q=0, word_cnt=0.
  - Outputs go to odata=0, oval=0, olast=0, rack=0, and idle=!rval.
  - Any partially emitted word is discarded; the FIFO is not popped during reset.
- oack while oval=0 is ignored.
- rdata is sampled only on a pop cycle.

## Timing
- Pop-to-first-slice latency is 1 cycle: a pop at edge N gives oval=1 with slice 0 after edge N.
- Sustained throughput is 1 slice/cycle with oack held high, i.e. 1 word per RATIO cycles.
- rack pulses for 1 cycle per word, coincident with olast transfer or with the EMPTY-state pop.
- Backpressure stalls the stream with zero slice loss and zero slice duplication.
- word_cnt is registered and updates the cycle after the pop.

## Test plan
- Single word, default params:
  - Stimulus: rdata=0x44332211, rval for one pop, oack=1.
  - Response: rack=1 for 1 cycle; odata = 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; olast only on 0x44; word_cnt=1; idle=1 afterwards.
- Back-to-back words:
  - Stimulus: FIFO holds 0xDDCCBBAA then 0x04030201; oack=1.
  - Response: 8 consecutive slices AA, BB, CC, DD, 01, 02, 03, 04 with no gap; the second rack coincides with the DD transfer; word_cnt=2.
- Backpressure:
  - Stimulus: word 0x44332211; oack=0 for 3 cycles while odata=0x22.
  - Response: odata stays 0x22, oval stays 1, rack=0; 0x33 follows after oack returns.
- Counter wrap:
  - Stimulus: CNT_WIDTH=2, pop 5 words.
  - Response: word_cnt sequence 1, 2, 3, 0, 1.
- Reset mid-word:
  - Stimulus: assert reset_n=0 after slice 0x22 of 0x44332211, asynchronously between edges.
  - Response: oval, olast, odata, idx, word_cnt go to 0 immediately; rack=0 while reset is asserted even with rval=1; after release the next FIFO word starts at slice 0.
- Under-run:
  - Stimulus: rval=0 after the last slice.
  - Response: oval drops the cycle after the olast transfer; no rack until rval=1.
